// File: rtl/branch_resolve_predict_unit.sv
// branch_resolve_predict_unit
// EX-stage branch/jump resolver with a 2-bit saturating-counter BHT that
// fetch reads for direction prediction. It registers the resolution result and
// raises a one-cycle REDIRECT pulse when fetch guessed wrong.
// Optional build macro: BJU_PERF_COUNTERS_EN adds BR_COUNT / MISPRED_COUNT.
module branch_resolve_predict_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            VALID_IN,
  input  logic            STALL,
  input  logic            KILL_IN,
  input  logic            branch_signal,
  input  logic            jump_signal,
  input  logic            jalr_signal,
  input  logic [2:0]      func_3,
  input  logic [XLEN-1:0] PC_IN,
  input  logic [XLEN-1:0] RS1_DATA,
  input  logic [XLEN-1:0] RS2_DATA,
  input  logic [XLEN-1:0] IMM,
  input  logic            PRED_TAKEN_IN,
  input  logic [XLEN-1:0] FETCH_PC,
  output logic            PRED_TAKEN,
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic [XLEN-1:0] LINK_ADDR,
  output logic            RESOLVED_TAKEN,
  output logic            ILLEGAL_BR
`ifdef BJU_PERF_COUNTERS_EN
  ,
  output logic [31:0]     BR_COUNT,
  output logic [31:0]     MISPRED_COUNT
`endif
);

  localparam logic [1:0]      CNT_RST = 2'b01;  // weakly not-taken
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);
  localparam logic [XLEN-1:0] LSB_CLR = ~XLEN'(1);

  logic [BHT_ENTRIES-1:0][1:0] bht_q;

  logic [BHT_IDX_W-1:0] fetch_idx, ex_idx;
  logic                 cap;
  logic                 is_jalr, is_jal, is_br;
  logic                 cond, illegal, taken, mispred, bht_we;
  logic [XLEN-1:0]      pc_plus4, target, next_pc;
  logic [1:0]           cnt_cur, cnt_d;

  logic            redirect_q, taken_q, illegal_q;
  logic [XLEN-1:0] rpc_q, link_q;

  // Low PC bits and bits above the index never reach the table.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{FETCH_PC[1:0], FETCH_PC[XLEN-1:BHT_IDX_W+2]};

  assign fetch_idx  = FETCH_PC[BHT_IDX_W+1:2];
  assign ex_idx     = PC_IN[BHT_IDX_W+1:2];
  // Read-before-write: fetch sees the registered counter, the update lands next edge.
  assign PRED_TAKEN = bht_q[fetch_idx][1];

  assign cap = VALID_IN & ~KILL_IN & ~STALL & (branch_signal | jump_signal | jalr_signal);

  // Decode control priority, evaluate condition, pick target and mispredict.
  always_comb begin
    is_jalr  = jalr_signal;
    is_jal   = jump_signal & ~jalr_signal;
    is_br    = branch_signal & ~jump_signal & ~jalr_signal;
    cond     = 1'b0;
    case (func_3)
      3'b000:  cond = (RS1_DATA == RS2_DATA);
      3'b001:  cond = (RS1_DATA != RS2_DATA);
      3'b100:  cond = ($signed(RS1_DATA) <  $signed(RS2_DATA));
      3'b101:  cond = ($signed(RS1_DATA) >= $signed(RS2_DATA));
      3'b110:  cond = (RS1_DATA <  RS2_DATA);
      3'b111:  cond = (RS1_DATA >= RS2_DATA);
      default: cond = 1'b0;
    endcase
    illegal  = is_br & (func_3[2:1] == 2'b01);
    taken    = is_jalr | is_jal | (is_br & cond);
    pc_plus4 = PC_IN + FOUR;
    target   = is_jalr ? ((RS1_DATA + IMM) & LSB_CLR) : (PC_IN + IMM);
    next_pc  = taken ? target : pc_plus4;
    // Direction-only BHT: unconditional jumps always redirect.
    mispred  = is_br ? (taken ^ PRED_TAKEN_IN) : 1'b1;
    bht_we   = cap & is_br & ~illegal;
  end

  // Saturating counter step for the EX instruction's entry.
  always_comb begin
    cnt_cur = bht_q[ex_idx];
    cnt_d   = cnt_cur;
    if (taken) begin
      if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'b01;
    end else begin
      if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'b01;
    end
  end

  // BHT storage: all entries weakly not-taken on reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_RST;
    end else if (bht_we) begin
      bht_q[ex_idx] <= cnt_d;
    end
  end

  // Resolution registers: pulses live one cycle, PCs hold until the next capture.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      redirect_q <= 1'b0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      rpc_q      <= '0;
      link_q     <= '0;
    end else begin
      redirect_q <= cap & mispred;
      taken_q    <= cap & taken;
      illegal_q  <= cap & illegal;
      if (cap) begin
        rpc_q  <= next_pc;
        link_q <= pc_plus4;
      end
    end
  end

  assign REDIRECT       = redirect_q;
  assign RESOLVED_TAKEN = taken_q;
  assign ILLEGAL_BR     = illegal_q;
  assign REDIRECT_PC    = rpc_q;
  assign LINK_ADDR      = link_q;

`ifdef BJU_PERF_COUNTERS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  // Saturating event counters: branch captures and redirects issued.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (cap & is_br & (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
      if (cap & mispred & (mp_cnt_q != 32'hFFFF_FFFF)) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign BR_COUNT      = br_cnt_q;
  assign MISPRED_COUNT = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_predict_unit.sv
// Scoreboard bench for branch_resolve_predict_unit: the stimulus process pushes
// expected results from a behavioural model, a monitor pops and compares.
module tb_branch_resolve_predict_unit;

  localparam int N = 64;

  logic        CLK, RESET, VALID_IN, STALL, KILL_IN;
  logic        branch_signal, jump_signal, jalr_signal;
  logic [2:0]  func_3;
  logic [31:0] PC_IN, RS1_DATA, RS2_DATA, IMM, FETCH_PC;
  logic        PRED_TAKEN_IN, PRED_TAKEN, REDIRECT, RESOLVED_TAKEN, ILLEGAL_BR;
  logic [31:0] REDIRECT_PC, LINK_ADDR;
`ifdef BJU_PERF_COUNTERS_EN
  logic [31:0] BR_COUNT, MISPRED_COUNT;
`endif

  branch_resolve_predict_unit #(.XLEN(32), .BHT_ENTRIES(N)) dut (
    .CLK(CLK), .RESET(RESET), .VALID_IN(VALID_IN), .STALL(STALL), .KILL_IN(KILL_IN),
    .branch_signal(branch_signal), .jump_signal(jump_signal), .jalr_signal(jalr_signal),
    .func_3(func_3), .PC_IN(PC_IN), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .IMM(IMM),
    .PRED_TAKEN_IN(PRED_TAKEN_IN), .FETCH_PC(FETCH_PC), .PRED_TAKEN(PRED_TAKEN),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .LINK_ADDR(LINK_ADDR),
    .RESOLVED_TAKEN(RESOLVED_TAKEN), .ILLEGAL_BR(ILLEGAL_BR)
`ifdef BJU_PERF_COUNTERS_EN
    , .BR_COUNT(BR_COUNT), .MISPRED_COUNT(MISPRED_COUNT)
`endif
  );

  typedef struct {
    int          cyc;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] link;
    logic        tk;
    logic        ill;
    logic [31:0] brc;
    logic [31:0] mpc;
  } exp_t;

  typedef struct {
    int   cyc;
    logic p;
  } pred_t;

  exp_t  exp_q[$];
  pred_t pred_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 0;

  // Reference model state
  int          cnt[N];
  logic [31:0] m_rpc, m_link, m_brc, m_mpc;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) cnt[i] = 1;
    m_rpc = 0; m_link = 0; m_brc = 0; m_mpc = 0;
  endtask

  // Drive one cycle of inputs, record expectations, advance to the next edge.
  task automatic step(input logic v, k, st, br, j, jr, input logic [2:0] f3,
                      input logic [31:0] pc, rs1, rs2, imm, input logic pt,
                      input logic [31:0] fpc);
    logic        c, is_br, cond, ill, tk, mis;
    logic [31:0] tgt;
    pred_t       pe;
    exp_t        e;
    VALID_IN = v; KILL_IN = k; STALL = st;
    branch_signal = br; jump_signal = j; jalr_signal = jr;
    func_3 = f3; PC_IN = pc; RS1_DATA = rs1; RS2_DATA = rs2; IMM = imm;
    PRED_TAKEN_IN = pt; FETCH_PC = fpc;
    pe.cyc = cyc; pe.p = (cnt[idx(fpc)] >= 2);
    pred_q.push_back(pe);
    c = v && !k && !st && (br || j || jr);
    is_br = br && !j && !jr;
    e.cyc = cyc; e.rd = 0; e.tk = 0; e.ill = 0;
    if (c) begin
      case (f3)
        3'd0: cond = (rs1 == rs2);
        3'd1: cond = (rs1 != rs2);
        3'd4: cond = ($signed(rs1) < $signed(rs2));
        3'd5: cond = !($signed(rs1) < $signed(rs2));
        3'd6: cond = (rs1 < rs2);
        3'd7: cond = !(rs1 < rs2);
        default: cond = 0;
      endcase
      ill = is_br && (f3 == 3'd2 || f3 == 3'd3);
      tk  = !is_br || cond;
      tgt = jr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
      mis = is_br ? (tk != pt) : 1'b1;
      m_rpc  = tk ? tgt : pc + 32'd4;
      m_link = pc + 32'd4;
      e.rd = mis; e.tk = tk; e.ill = ill;
      if (is_br) m_brc++;
      if (mis) m_mpc++;
      if (is_br && !ill) begin
        if (tk && cnt[idx(pc)] < 3) cnt[idx(pc)]++;
        if (!tk && cnt[idx(pc)] > 0) cnt[idx(pc)]--;
      end
    end
    e.rpc = m_rpc; e.link = m_link; e.brc = m_brc; e.mpc = m_mpc;
    exp_q.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic br_step(input logic [2:0] f3, input logic [31:0] pc, rs1, rs2, imm,
                         input logic pt);
    step(1, 0, 0, 1, 0, 0, f3, pc, rs1, rs2, imm, pt, pc);
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0, fpc);
  endtask

  // Monitor: combinational prediction mid-cycle, registered results one edge later.
  initial begin
    pred_t pe;
    exp_t  e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (pred_q.size() > 0 && pred_q[0].cyc == cyc) begin
          pe = pred_q.pop_front();
          chk("pred_taken", {31'd0, PRED_TAKEN}, {31'd0, pe.p});
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          chk("redirect", {31'd0, REDIRECT}, {31'd0, e.rd});
          chk("redirect_pc", REDIRECT_PC, e.rpc);
          chk("link_addr", LINK_ADDR, e.link);
          chk("resolved_taken", {31'd0, RESOLVED_TAKEN}, {31'd0, e.tk});
          chk("illegal_br", {31'd0, ILLEGAL_BR}, {31'd0, e.ill});
`ifdef BJU_PERF_COUNTERS_EN
          chk("br_count", BR_COUNT, e.brc);
          chk("mispred_count", MISPRED_COUNT, e.mpc);
`endif
        end
      end
    end
  end

  initial begin
    logic [31:0] pc, rs1;
    RESET = 0; VALID_IN = 0; STALL = 0; KILL_IN = 0;
    branch_signal = 0; jump_signal = 0; jalr_signal = 0; func_3 = 0;
    PC_IN = 0; RS1_DATA = 0; RS2_DATA = 0; IMM = 0; PRED_TAKEN_IN = 0; FETCH_PC = 32'h40;
    model_reset();
    #12;
    chk("rst_redirect", {31'd0, REDIRECT}, 32'd0);
    chk("rst_rpc", REDIRECT_PC, 32'd0);
    chk("rst_link", LINK_ADDR, 32'd0);
    chk("rst_pred", {31'd0, PRED_TAKEN}, 32'd0);
    @(negedge CLK); RESET = 1;
    @(posedge CLK); #1;
    mon_en = 1;

    // BEQ taken, predicted not-taken; counter 01 -> 10
    idle(32'h40);
    br_step(3'b000, 32'h40, 32'd5, 32'd5, 32'h10, 0);
    idle(32'h40);
    // BLT / BLTU on 0xFFFFFFFF vs 1, correctly predicted
    br_step(3'b100, 32'h60, 32'hFFFF_FFFF, 32'd1, 32'h20, 1);
    br_step(3'b110, 32'h64, 32'hFFFF_FFFF, 32'd1, 32'h20, 0);
    // JALR
    step(1, 0, 0, 0, 0, 1, 3'd0, 32'h100, 32'h203, 32'h0, 32'h4, 0, 32'h100);
    // saturate at 11, then step down; lookup aliases the updated entry
    for (int i = 0; i < 4; i++) br_step(3'b001, 32'h80, 32'd1, 32'd2, 32'h8, 0);
    br_step(3'b000, 32'h80, 32'd1, 32'd2, 32'h8, 1);
    idle(32'h80);
    // stall and kill suppress capture; illegal func_3
    step(1, 0, 1, 1, 0, 0, 3'b000, 32'h40, 32'd7, 32'd7, 32'h40, 0, 32'h40);
    step(1, 1, 0, 1, 0, 0, 3'b000, 32'h40, 32'd7, 32'd7, 32'h40, 0, 32'h40);
    br_step(3'b010, 32'h44, 32'd7, 32'd7, 32'h40, 0);
    idle(32'h40);

    // randomized phase
    for (int n = 0; n < 400; n++) begin
      pc  = $urandom_range(0, 255) << 2;
      rs1 = $urandom();
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           3'($urandom_range(0, 7)), pc, rs1,
           ($urandom_range(0, 2) == 0) ? rs1 : $urandom(), $urandom(),
           $urandom_range(0, 1), $urandom_range(0, 255) << 2);
    end

    // drive entry of 0x300 to 00 ahead of the reset test
    for (int i = 0; i < 3; i++) br_step(3'b000, 32'h300, 32'd1, 32'd2, 32'h4, 0);
    idle(32'h300);
    @(negedge CLK); #1;
    mon_en = 0;
    chk("drain_before_reset", exp_q.size() + pred_q.size(), 32'd0);

    // async reset while REDIRECT is high
    @(posedge CLK); #1;
    VALID_IN = 1; jump_signal = 1; branch_signal = 0; jalr_signal = 0;
    STALL = 0; KILL_IN = 0; PC_IN = 32'h200; IMM = 32'h8;
    @(posedge CLK); #1;
    VALID_IN = 0; jump_signal = 0;
    chk("pre_reset_redirect", {31'd0, REDIRECT}, 32'd1);
    #2 RESET = 0;
    #1;
    chk("async_rst_redirect", {31'd0, REDIRECT}, 32'd0);
    chk("async_rst_taken", {31'd0, RESOLVED_TAKEN}, 32'd0);
    chk("async_rst_rpc", REDIRECT_PC, 32'd0);
    chk("async_rst_link", LINK_ADDR, 32'd0);
`ifdef BJU_PERF_COUNTERS_EN
    chk("async_rst_brc", BR_COUNT, 32'd0);
    chk("async_rst_mpc", MISPRED_COUNT, 32'd0);
`endif
    #1 RESET = 1;
    model_reset();
    @(posedge CLK); #1;
    mon_en = 1;
    // one taken branch from 01 must predict taken afterwards
    br_step(3'b000, 32'h300, 32'd3, 32'd3, 32'h4, 0);
    idle(32'h300);
    idle(32'h300);
    @(negedge CLK); #1;
    chk("drain_end", exp_q.size() + pred_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_predict_unit.md
Name: branch_resolve_predict_unit

Overview:
- Parametrised next-generation branch/jump unit: resolves all six RV32I conditional branches plus JAL/JALR in the EX stage.
- Compares RS1/RS2 internally; no ALU flag inputs.
- Holds a 2-bit saturating-counter branch history table (BHT) that fetch reads for direction prediction.
- Registers the resolution result and issues a one-cycle redirect pulse to fetch/IF-ID flush logic on mispredict.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 2.
- BHT_IDX_W, $clog2(BHT_ENTRIES), index width; BHT index = PC[BHT_IDX_W+1:2].

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- VALID_IN  in  1  EX-stage instruction valid.
- STALL  in  1  pipeline stall; inhibits capture and BHT update.
- KILL_IN  in  1  squash EX instruction (older redirect); treated as VALID_IN=0.
- branch_signal  in  1  conditional branch.
- jump_signal  in  1  JAL.
- jalr_signal  in  1  JALR.
- func_3  in  3  branch condition code.
- PC_IN  in  XLEN  PC of EX instruction.
- RS1_DATA  in  XLEN  operand 1.
- RS2_DATA  in  XLEN  operand 2.
- IMM  in  XLEN  sign-extended immediate.
- PRED_TAKEN_IN  in  1  direction predicted at fetch for this instruction.
- FETCH_PC  in  XLEN  fetch lookup address.
- PRED_TAKEN  out  1  combinational prediction = BHT[idx(FETCH_PC)][1].
- REDIRECT  out  1  registered one-cycle mispredict pulse.
- REDIRECT_PC  out  XLEN  registered correct next PC.
- LINK_ADDR  out  XLEN  registered PC_IN+4 for JAL/JALR writeback.
- RESOLVED_TAKEN  out  1  registered actual direction.
- ILLEGAL_BR  out  1  registered pulse for func_3 010/011 with branch_signal.

Behaviour:
- Reset (RESET=0, async): REDIRECT, RESOLVED_TAKEN, ILLEGAL_BR = 0; REDIRECT_PC, LINK_ADDR = 0; every BHT counter = 2'b01 (weakly not-taken). Reset mid-operation drops any pending pulse immediately.
- Capture condition: cap = VALID_IN & ~KILL_IN & ~STALL & (branch_signal|jump_signal|jalr_signal).
- Condition decode: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 → not taken, ILLEGAL_BR=1.
- taken = jump_signal | jalr_signal | (branch_signal & cond).
- Target: branch/JAL = PC_IN+IMM. JALR = (RS1_DATA+IMM) & ~1. All sums modulo 2^XLEN (wrap, no overflow flag).
- Control-signal priority: jalr_signal > jump_signal > branch_signal.
- Mispredict:
  - conditional branch: taken != PRED_TAKEN_IN;
  - JAL/JALR: always redirect (BHT predicts direction only).
- REDIRECT_PC = taken ? target : PC_IN+4.
- Latency: on the edge where cap=1, all registered outputs load; REDIRECT, ILLEGAL_BR and RESOLVED_TAKEN are high for exactly one cycle; REDIRECT_PC/LINK_ADDR hold until the next capture.
- When cap=0, pulse outputs return to 0 on that edge.
- STALL=1: no capture, no BHT write, pulse outputs cleared.
- BHT update: same edge as capture, conditional branches only (not JAL/JALR, not illegal). Taken: increment, saturating at 11. Not taken: decrement, saturating at 00.
- Lookup/update collision on the same index in the same cycle: PRED_TAKEN shows the pre-update value (read-before-write). The new value is visible from the next cycle.
- Index aliasing permitted; no tags.

Optional Feature:
- Macro BJU_PERF_COUNTERS_EN.
- Defined: adds outputs BR_COUNT[31:0] and MISPRED_COUNT[31:0].
  - BR_COUNT increments on every conditional-branch capture; MISPRED_COUNT increments on every REDIRECT.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then FETCH_PC=0x40 → PRED_TAKEN=0; BEQ at PC 0x40, RS1=RS2=5, IMM=0x10, PRED_TAKEN_IN=0 → next cycle REDIRECT=1, REDIRECT_PC=0x50, counter 01→10, PRED_TAKEN for 0x40 becomes 1.
- BLT RS1=0xFFFFFFFF, RS2=1 → taken. BLTU, same operands → not taken. With PRED_TAKEN_IN matching actual in both cases → REDIRECT=0.
- JALR PC=0x100, RS1=0x203, IMM=4 → REDIRECT_PC=0x206, LINK_ADDR=0x104, REDIRECT=1, BHT unchanged.
- Four taken branches at the same index → counter saturates at 11. Fifth update, not taken → 10. Same-cycle lookup during the fourth update still returns the old value.
- Branch with STALL=1, then KILL_IN=1 → no REDIRECT, BHT unchanged. func_3=010 → ILLEGAL_BR=1, REDIRECT_PC=PC+4.
- Assert RESET=0 asynchronously in the cycle REDIRECT is high → REDIRECT falls without a clock edge, all counters return to 01. With BJU_PERF_COUNTERS_EN defined, counters read 0.
